// File: rtl/alu_pkg.sv
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared datapath widths, selector codes and skid-stage states
//                for the ALU result path.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam int ALU_DATA_WIDTH = 24;
    localparam int ALU_SEL_WIDTH  = 3;

    // Codes 4..7 are reserved for future function units.
    typedef enum logic [ALU_SEL_WIDTH-1:0] {
        SEL_AND  = 3'd0,
        SEL_OR   = 3'd1,
        SEL_ADD  = 3'd2,
        SEL_LESS = 3'd3
    } alu_sel_e;

    // Encoded as {main_valid, skid_valid}.
    typedef enum logic [1:0] {
        SKID_EMPTY = 2'b00,
        SKID_ONE   = 2'b10,
        SKID_FULL  = 2'b11
    } skid_state_e;

endpackage

`default_nettype wire

// File: rtl/skid_buffer_reg.sv
// ============================================================================
//  Module      : skid_buffer_reg
//  Description : Generic 2-entry valid/ready register stage with a registered
//                in_ready, sustaining one transfer per cycle under stalls.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module skid_buffer_reg
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_payload,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_payload,
    output logic             out_valid,
    input  logic             out_ready
);

    skid_state_e      r_state;
    skid_state_e      w_state_nxt;
    logic             w_load_main;
    logic             w_load_skid;
    logic             w_main_from_skid;
    logic [WIDTH-1:0] r_main_data;
    logic [WIDTH-1:0] r_skid_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SKID_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // in_ready is 1 in EMPTY/ONE, so in_valid alone implies an accept there.
    always_comb begin
        w_state_nxt      = r_state;
        w_load_main      = 1'b0;
        w_load_skid      = 1'b0;
        w_main_from_skid = 1'b0;
        case (r_state)
            SKID_EMPTY: begin
                if (in_valid) begin
                    w_state_nxt = SKID_ONE;
                    w_load_main = 1'b1;
                end
            end
            SKID_ONE: begin
                if (in_valid && out_ready) begin
                    w_load_main = 1'b1;
                end else if (in_valid) begin
                    w_state_nxt = SKID_FULL;
                    w_load_skid = 1'b1;
                end else if (out_ready) begin
                    w_state_nxt = SKID_EMPTY;
                end
            end
            SKID_FULL: begin
                if (out_ready) begin
                    w_state_nxt      = SKID_ONE;
                    w_main_from_skid = 1'b1;
                end
            end
            default: begin
                w_state_nxt = SKID_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_data <= '0;
            r_skid_data <= '0;
        end else begin
            if (w_load_main) begin
                r_main_data <= in_payload;
            end else if (w_main_from_skid) begin
                r_main_data <= r_skid_data;
            end
            if (w_load_skid) begin
                r_skid_data <= in_payload;
            end
        end
    end

    assign out_valid   = r_state[1];
    assign in_ready    = ~r_state[0];
    assign out_payload = r_main_data;

endmodule

`default_nettype wire

// File: rtl/alu_result_select_pipe.sv
// ============================================================================
//  Module      : alu_result_select_pipe
//  Description : Registered N-way ALU result selector with skid buffering and
//                sticky illegal-selector flag. ALU_ZERO_FLAG_EN adds out_zero.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_result_select_pipe
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = ALU_DATA_WIDTH,
    parameter int NUM_INPUTS = 4,
    parameter int SEL_WIDTH  = ALU_SEL_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
    input  logic [SEL_WIDTH-1:0]             in_sel,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic [SEL_WIDTH-1:0]             out_sel,
    output logic                             out_valid,
    input  logic                             out_ready,
    input  logic                             err_clr,
`ifdef ALU_ZERO_FLAG_EN
    output logic                             sel_err,
    output logic                             out_zero
`else
    output logic                             sel_err
`endif
);

`ifdef ALU_ZERO_FLAG_EN
    localparam int c_payload_w = DATA_WIDTH + SEL_WIDTH + 1;
`else
    localparam int c_payload_w = DATA_WIDTH + SEL_WIDTH;
`endif
    localparam logic [SEL_WIDTH:0] c_num_inputs = (SEL_WIDTH + 1)'(NUM_INPUTS);

    logic [DATA_WIDTH-1:0]  w_sel_data;
    logic                   w_sel_illegal;
    logic                   w_accept;
    logic [c_payload_w-1:0] w_in_payload;
    logic [c_payload_w-1:0] w_out_payload;
    logic                   r_sel_err;

    // Illegal codes match no lane and therefore fall through to zero.
    always_comb begin
        w_sel_data = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            if (in_sel == SEL_WIDTH'(k)) begin
                w_sel_data = in_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_sel_illegal = ({1'b0, in_sel} >= c_num_inputs);
    assign w_accept      = in_valid && in_ready;

`ifdef ALU_ZERO_FLAG_EN
    assign w_in_payload = {(w_sel_data == '0), in_sel, w_sel_data};
    assign {out_zero, out_sel, out_data} = w_out_payload;
`else
    assign w_in_payload = {in_sel, w_sel_data};
    assign {out_sel, out_data} = w_out_payload;
`endif

    skid_buffer_reg #(
        .WIDTH (c_payload_w)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .in_payload  (w_in_payload),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_payload (w_out_payload),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    // Setting on an illegal accept outranks a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel_err <= 1'b0;
        end else if (w_accept && w_sel_illegal) begin
            r_sel_err <= 1'b1;
        end else if (err_clr) begin
            r_sel_err <= 1'b0;
        end
    end

    assign sel_err = r_sel_err;

endmodule

`default_nettype wire

// File: tb/tb_alu_result_select_pipe.sv
// ============================================================================
//  Module      : tb_alu_result_select_pipe
//  Description : Directed + randomised bench for alu_result_select_pipe with a
//                queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_result_select_pipe;

    localparam int DW = 24;
    localparam int NI = 4;
    localparam int SW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] lane [NI];
    logic [NI*DW-1:0] in_data;
    logic [SW-1:0] in_sel = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic [SW-1:0] out_sel;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          err_clr = 1'b0;
    logic          sel_err;
`ifdef ALU_ZERO_FLAG_EN
    logic          out_zero;
`endif

    int checks = 0;
    int errors = 0;

    assign in_data = {lane[3], lane[2], lane[1], lane[0]};

    always #5 clk = ~clk;

    alu_result_select_pipe #(
        .DATA_WIDTH (DW),
        .NUM_INPUTS (NI),
        .SEL_WIDTH  (SW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_clr   (err_clr),
        .sel_err   (sel_err)
`ifdef ALU_ZERO_FLAG_EN
        , .out_zero (out_zero)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: the block is a 2-deep FIFO of {sel, result}.
    logic [SW+DW-1:0] q[$];
    logic             m_err = 1'b0;
    logic             m_live = 1'b0;

    always @(posedge clk) begin
        logic acc;
        logic xf;
        if (rst) begin
            q.delete();
            m_err  = 1'b0;
            m_live = 1'b1;
        end else begin
            acc = in_valid && (q.size() < 2);
            xf  = (q.size() > 0) && out_ready;
            if (xf) void'(q.pop_front());
            if (acc) q.push_back({in_sel, (int'(in_sel) < NI) ? lane[in_sel[1:0]] : {DW{1'b0}}});
            if (acc && int'(in_sel) >= NI) m_err = 1'b1;
            else if (err_clr) m_err = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("m_out_valid", 32'(out_valid), 32'(q.size() > 0));
            chk("m_in_ready", 32'(in_ready), 32'(q.size() < 2));
            chk("m_sel_err", 32'(sel_err), 32'(m_err));
            if (q.size() > 0) begin
                chk("m_out_data", 32'(out_data), 32'(q[0][DW-1:0]));
                chk("m_out_sel", 32'(out_sel), 32'(q[0][SW+DW-1:DW]));
`ifdef ALU_ZERO_FLAG_EN
                chk("m_out_zero", 32'(out_zero), 32'(q[0][DW-1:0] == '0));
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [DW-1:0] exp_stream [4];

    initial begin
        lane[0] = 24'h00000A;
        lane[1] = 24'h0000F0;
        lane[2] = 24'h123456;
        lane[3] = 24'h000001;
        exp_stream[0] = 24'h00000A;
        exp_stream[1] = 24'h0000F0;
        exp_stream[2] = 24'h123456;
        exp_stream[3] = 24'h000001;

        repeat (2) tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_sel_err", 32'(sel_err), 32'd0);
        rst = 1'b0;
        tick();

        // Single transaction, one-cycle latency
        in_sel = 3'd2; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_data", 32'(out_data), 32'h123456);
        chk("single_sel", 32'(out_sel), 32'd2);
        tick();

        // Back-to-back stream
        for (int i = 0; i < 4; i++) begin
            in_sel = SW'(i); in_valid = 1'b1;
            tick();
            chk("stream_data", 32'(out_data), 32'(exp_stream[i]));
            chk("stream_in_ready", 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        tick();

        // Back-pressure: two accepted, third refused
        out_ready = 1'b0;
        in_sel = 3'd0; in_valid = 1'b1;
        tick();
        in_sel = 3'd1;
        tick();
        chk("bp_full_ready", 32'(in_ready), 32'd0);
        in_sel = 3'd3;
        tick();
        chk("bp_hold_data", 32'(out_data), 32'h00000A);
        chk("bp_hold_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("bp_second_data", 32'(out_data), 32'h0000F0);
        chk("bp_second_sel", 32'(out_sel), 32'd1);
        chk("bp_ready_back", 32'(in_ready), 32'd1);
        tick();
        chk("bp_drained", 32'(out_valid), 32'd0);

        // Illegal selector and sticky error
        in_sel = 3'd5; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("ill_data", 32'(out_data), 32'd0);
        chk("ill_sel", 32'(out_sel), 32'd5);
        chk("ill_err", 32'(sel_err), 32'd1);
        tick();
        chk("ill_err_sticky", 32'(sel_err), 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("err_cleared", 32'(sel_err), 32'd0);
        err_clr = 1'b1; in_sel = 3'd7; in_valid = 1'b1;
        tick();
        err_clr = 1'b0; in_valid = 1'b0;
        chk("err_set_wins", 32'(sel_err), 32'd1);
        chk("ill7_sel", 32'(out_sel), 32'd7);
        tick();

        // Reset while FULL
        out_ready = 1'b0;
        in_sel = 3'd2; in_valid = 1'b1;
        tick();
        in_sel = 3'd3;
        tick();
        in_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_data", 32'(out_data), 32'd0);
        chk("mid_rst_err", 32'(sel_err), 32'd0);
        out_ready = 1'b1;
        repeat (3) tick();
        chk("no_stale", 32'(out_valid), 32'd0);

`ifdef ALU_ZERO_FLAG_EN
        lane[0] = 24'h000000;
        in_sel = 3'd0; in_valid = 1'b1;
        tick();
        chk("zero_set", 32'(out_zero), 32'd1);
        in_sel = 3'd1;
        tick();
        in_valid = 1'b0;
        chk("zero_clr", 32'(out_zero), 32'd0);
        tick();
`endif

        // Mixed traffic against the model
        for (int n = 0; n < 400; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_sel    = SW'($urandom_range(0, 7));
            out_ready = ($urandom_range(0, 2) != 0);
            err_clr   = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 7) == 0) lane[$urandom_range(0, 3)] = DW'($urandom_range(0, 3) == 0 ? 0 : $urandom);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1; err_clr = 1'b0;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_result_select_pipe.md
Name: alu_result_select_pipe

Overview:
- Parametrised, registered N-way result selector for the 24-bit CPU datapath.
- Sits between the ALU function units (AND, OR, adder, LESS, and later shift, XOR, etc.) and the writeback stage.
- Selects one of NUM_INPUTS operand lanes and registers the result behind a valid/ready handshake.
- A 2-entry skid buffer sustains one result per cycle under back-pressure; out-of-range selector codes are flagged.

Parameters:
- DATA_WIDTH, 24, width of each input lane and of the result.
- NUM_INPUTS, 4, number of selectable lanes; legal range 2..2**SEL_WIDTH.
- SEL_WIDTH, 3, selector width; codes NUM_INPUTS..2**SEL_WIDTH-1 are illegal.

Ports:
- Clock  input  1  single clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high.
- in_data  input  NUM_INPUTS*DATA_WIDTH  flattened lanes; lane k = in_data[k*DATA_WIDTH +: DATA_WIDTH].
- in_sel  input  SEL_WIDTH  lane selector, sampled with in_data.
- in_valid  input  1  upstream offers a transaction.
- in_ready  output  1  block can accept.
- out_data  output  DATA_WIDTH  selected, registered result.
- out_sel  output  SEL_WIDTH  selector that produced out_data.
- out_valid  output  1  out_data/out_sel are valid.
- out_ready  input  1  downstream accepts.
- err_clr  input  1  clears sel_err.
- sel_err  output  1  sticky: an illegal in_sel was accepted.

Interface note: one clock; reset is synchronous and active-high.

Behaviour:
- Handshakes:
  - Accept occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - in_data and in_sel are sampled only on accept.
- Selection:
  - Legal in_sel: result = lane[in_sel].
  - Illegal in_sel (>= NUM_INPUTS): result = 0, the transaction still completes, and sel_err sets on the following edge.
- Storage: main register (drives the outputs) plus one skid register.
- in_ready = !skid_valid. It is registered; there is no combinational path from out_ready.
- Latency: 1 cycle, accept at edge N gives out_valid high after edge N. Throughput is 1 per cycle while out_ready is held high.
- States are encoded by (main_valid, skid_valid): EMPTY (0,0), ONE (1,0), FULL (1,1).
  - EMPTY + accept -> ONE.
  - ONE + accept + transfer -> ONE; main reloads with the new data.
  - ONE + accept, no transfer -> FULL; new data goes to skid.
  - ONE + transfer, no accept -> EMPTY.
  - FULL + transfer -> ONE; main loads from skid. No accept is possible in FULL since in_ready = 0.
  - FULL with no transfer holds.
- While out_valid && !out_ready, out_data and out_sel are stable.
- Ordering is strictly FIFO; no transaction is dropped or duplicated.
- Reset takes priority over everything:
  - main_valid = skid_valid = 0, so out_valid = 0 and in_ready = 1 after the reset edge.
  - out_data = 0, out_sel = 0, sel_err = 0, out_zero = 0.
  - Reset asserted mid-stream discards all held data.
- sel_err: set on accept of an illegal code; cleared on err_clr. If both occur in the same cycle, set wins. It is held otherwise.

Optional Feature:
- Macro: ALU_ZERO_FLAG_EN.
- Defined:
  - Adds output port out_zero (1 bit), equal to (out_data == 0) of the held result.
  - It is computed at capture time and stored alongside the data in both the main and skid registers, so it carries no extra combinational depth on the output.
- Undefined:
  - The port is absent and no flag storage is built.

Decomposition:
- Shared package alu_pkg:
  - ALU_DATA_WIDTH = 24 and ALU_SEL_WIDTH = 3.
  - Enum of selector codes: SEL_AND = 0, SEL_OR = 1, SEL_ADD = 2, SEL_LESS = 3; 4..7 reserved.
- One natural sub-module, skid_buffer_reg: a generic 2-entry valid/ready stage, parametrised on payload width. The payload is {zero?, sel, data}.
- The lane selection logic lives in the top module.

Test Plan:
- Reset, then lanes {0x00000A, 0x0000F0, 0x123456, 0x000001}; send sel = 2 with out_ready = 1 -> one cycle later out_valid = 1, out_data = 0x123456, out_sel = 2.
- Stream sel 0,1,2,3 on back-to-back cycles with out_ready = 1 -> outputs 0x00000A, 0x0000F0, 0x123456, 0x000001 on consecutive cycles; in_ready stays 1.
- Hold out_ready = 0 and offer 3 transactions -> 2 accepted, then in_ready = 0. Raise out_ready -> both delivered in order, in_ready returns to 1 one cycle after the first transfer.
- Send sel = 5 -> out_data = 0, out_sel = 5, sel_err = 1 and stays set. Pulse err_clr -> sel_err = 0. Pulse err_clr in the same cycle as an accepted sel = 7 -> sel_err = 1.
- Fill to FULL, assert Reset for one cycle -> out_valid = 0, in_ready = 1, out_data = 0, and no stale data appears after reset.
- With ALU_ZERO_FLAG_EN defined: sel = 0 with lane0 = 0 -> out_zero = 1; sel = 1 with lane1 = 0x0000F0 -> out_zero = 0.
